// File: rtl/regarb_pkg.sv
// ============================================================================
// regarb_pkg : state encoding, requester indices and round-robin helper
// Revision   : 1.0
// ============================================================================
`default_nettype none

package regarb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    localparam logic REQ_DBG = 1'b0;
    localparam logic REQ_INI = 1'b1;

    // On a tie the requester that was not served last wins.
    function automatic logic rr_pick(input logic req_dbg, input logic req_ini, input logic last);
        if (req_dbg && req_ini) begin
            return ~last;
        end
        return req_ini ? REQ_INI : REQ_DBG;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regarb.sv
// ============================================================================
// regarb   : two-requester round-robin arbiter for a shared register write bus
// Revision : 1.0
// ============================================================================
`default_nettype none

module regarb
    import regarb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dbgreq,
    input  logic [7:0] dbgaddr,
    input  logic [7:0] dbgwdata,
    output logic       dbgack,
    input  logic       inireq,
    input  logic [7:0] iniaddr,
    input  logic [7:0] iniwdata,
    output logic       iniack,
    output logic [7:0] regaddr,
    output logic [7:0] regwdata,
    output logic       regwe,
    input  logic       regready,
    output logic       toerr,
    output logic       busy
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0] state, state_nxt;
    logic       ptr, ptr_nxt;
    logic       gnt, gnt_nxt;
    logic       just_acked, just_acked_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] regaddr_nxt, regwdata_nxt;
    logic       regwe_nxt, dbgack_nxt, iniack_nxt, toerr_nxt, busy_nxt;
    logic       dbg_eff, ini_eff, timed_out;

    // The requester acked last may still show req in the first idle cycle.
    assign dbg_eff   = dbgreq && !(just_acked && (ptr == REQ_DBG));
    assign ini_eff   = inireq && !(just_acked && (ptr == REQ_INI));
    assign timed_out = !regready && (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= REQ_INI;
            gnt        <= REQ_DBG;
            just_acked <= 1'b0;
            cnt        <= '0;
            regaddr    <= '0;
            regwdata   <= '0;
            regwe      <= 1'b0;
            dbgack     <= 1'b0;
            iniack     <= 1'b0;
            toerr      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            gnt        <= gnt_nxt;
            just_acked <= just_acked_nxt;
            cnt        <= cnt_nxt;
            regaddr    <= regaddr_nxt;
            regwdata   <= regwdata_nxt;
            regwe      <= regwe_nxt;
            dbgack     <= dbgack_nxt;
            iniack     <= iniack_nxt;
            toerr      <= toerr_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (dbg_eff || ini_eff) state_nxt = ST_WRITE;
            ST_WRITE: if (regready || timed_out) state_nxt = ST_ACK;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead so every port comes from a flop.
    always_comb begin
        ptr_nxt        = ptr;
        gnt_nxt        = gnt;
        just_acked_nxt = 1'b0;
        cnt_nxt        = cnt;
        regaddr_nxt    = regaddr;
        regwdata_nxt   = regwdata;
        regwe_nxt      = 1'b0;
        dbgack_nxt     = 1'b0;
        iniack_nxt     = 1'b0;
        toerr_nxt      = toerr;
        busy_nxt       = (state_nxt != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (dbg_eff || ini_eff) begin
                    gnt_nxt      = rr_pick(dbg_eff, ini_eff, ptr);
                    regaddr_nxt  = (gnt_nxt == REQ_INI) ? iniaddr  : dbgaddr;
                    regwdata_nxt = (gnt_nxt == REQ_INI) ? iniwdata : dbgwdata;
                    regwe_nxt    = 1'b1;
                    cnt_nxt      = '0;
                end
            end
            ST_WRITE: begin
                if (regready || timed_out) begin
                    dbgack_nxt = (gnt == REQ_DBG);
                    iniack_nxt = (gnt == REQ_INI);
                    if (!regready) begin
                        toerr_nxt = 1'b1;
                    end
                end else begin
                    regwe_nxt = 1'b1;
                    cnt_nxt   = cnt + 8'd1;
                end
            end
            ST_ACK: begin
                ptr_nxt        = gnt;
                just_acked_nxt = 1'b1;
            end
            default: begin
                ptr_nxt = ptr;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_regarb.sv
// Self-checking bench for regarb: requester drivers push expected writes into
// per-requester queues; a negedge monitor applies the arbitration rules and compares.
`default_nettype none

module tb_regarb;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_v = 2'b00;
    logic [7:0]  addr_v [2];
    logic [7:0]  data_v [2];
    logic        regready;
    logic        dbgack, iniack, regwe, toerr, busy;
    logic [7:0]  regaddr, regwdata;

    int n_cmp = 0;
    int n_bad = 0;

    int mode  = 1;
    int lowcfg = 0;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];

    regarb #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .dbgreq   (req_v[0]),
        .dbgaddr  (addr_v[0]),
        .dbgwdata (data_v[0]),
        .dbgack   (dbgack),
        .inireq   (req_v[1]),
        .iniaddr  (addr_v[1]),
        .iniwdata (data_v[1]),
        .iniack   (iniack),
        .regaddr  (regaddr),
        .regwdata (regwdata),
        .regwe    (regwe),
        .regready (regready),
        .toerr    (toerr),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ack_of(input int r);
        return (r == 1) ? iniack : dbgack;
    endfunction

    // One write from requester r: raise req, hold until ack, drop the cycle after
    // (or one cycle later when linger is set).
    task automatic do_write(input int r, input logic [7:0] a, input logic [7:0] d, input logic linger);
        int waited;
        @(posedge clk); #1;
        addr_v[r] = a;
        data_v[r] = d;
        req_v[r]  = 1'b1;
        if (r == 1) q1.push_back({a, d}); else q0.push_back({a, d});
        waited = 0;
        forever begin
            @(posedge clk); #1;
            if (ack_of(r)) break;
            waited++;
            if (waited > 200) begin
                chk($sformatf("ack_wait_r%0d", r), 32'(0), 32'(1));
                break;
            end
        end
        @(posedge clk); #1;
        if (linger) begin
            @(posedge clk); #1;
        end
        req_v[r] = 1'b0;
    endtask

    task automatic pulse_rst();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic wait_we();
        int n;
        n = 0;
        while (!regwe && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("wait_we", 32'(regwe), 32'(1));
    endtask

    task automatic rand_req(input int r, input int count);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_write(r, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end
    endtask

    // Slave: random ready, or ready after lowcfg write cycles of the current write.
    int   wk = 0;
    logic sl_prev = 1'b0;
    initial begin
        regready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (regwe) wk = sl_prev ? wk + 1 : 0;
            sl_prev = regwe;
            if (mode == 0) regready = ($urandom_range(0, 2) == 0);
            else           regready = regwe && (wk >= lowcfg);
        end
    end

    // Monitor / reference model state
    logic        h_rst = 1'b1;
    logic        h_regwe = 1'b0;
    logic [1:0]  h_ack = 2'b00;
    logic [1:0]  h2_ack = 2'b00;
    logic [1:0]  h_req = 2'b00;
    logic        last = 1'b1;
    logic        toerr_m = 1'b0;
    logic        in_write = 1'b0;
    logic        ack_due = 1'b0;
    logic        to_due = 1'b0;
    logic        wg = 1'b0;
    logic [15:0] wbus = '0;
    int          lowcnt = 0;
    logic [1:0]  cur_ack, elig, exp_ack;
    logic        start, exp_start, idle_c, g;

    always @(negedge clk) begin
        cur_ack = {iniack, dbgack};
        if (h_rst) begin
            chk("rst_regwe", 32'(regwe), 32'(0));
            chk("rst_ack", 32'(cur_ack), 32'(0));
            chk("rst_toerr", 32'(toerr), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_bus", 32'({regaddr, regwdata}), 32'(0));
            last = 1'b1; toerr_m = 1'b0; in_write = 1'b0; ack_due = 1'b0; to_due = 1'b0;
        end else begin
            exp_ack = 2'b00;
            if (ack_due) begin
                exp_ack = wg ? 2'b10 : 2'b01;
                chk("we_drop", 32'(regwe), 32'(0));
                if (to_due) toerr_m = 1'b1;
                last = wg;
                if (wg && q1.size() > 0) void'(q1.pop_front());
                if (!wg && q0.size() > 0) void'(q0.pop_front());
                in_write = 1'b0; ack_due = 1'b0; to_due = 1'b0;
            end
            chk("ack", 32'(cur_ack), 32'(exp_ack));
            elig      = h_req & ~h2_ack;
            idle_c    = !h_regwe && (h_ack == 2'b00);
            exp_start = idle_c && (elig != 2'b00);
            start     = regwe && !h_regwe;
            if (idle_c || start) chk("grant", 32'(start), 32'(exp_start));
            if (exp_start) begin
                g = (elig == 2'b11) ? ~last : elig[1];
                if ((g ? q1.size() : q0.size()) == 0) begin
                    chk("grant_queue", 32'(0), 32'(1));
                    wbus = '0;
                end else begin
                    wbus = g ? q1[0] : q0[0];
                    chk($sformatf("bus_start_r%0d", g), 32'({regaddr, regwdata}), 32'(wbus));
                end
                in_write = 1'b1; wg = g; lowcnt = 0;
            end else if (in_write) begin
                chk("we_held", 32'(regwe), 32'(1));
                chk("bus_stable", 32'({regaddr, regwdata}), 32'(wbus));
            end
            if (in_write) begin
                if (regready) begin
                    ack_due = 1'b1;
                end else begin
                    lowcnt++;
                    if (lowcnt == TO) begin
                        ack_due = 1'b1;
                        to_due  = 1'b1;
                    end
                end
            end
            chk("toerr", 32'(toerr), 32'(toerr_m));
            chk("busy", 32'(busy), 32'(regwe | dbgack | iniack));
        end
        if (h_rst) begin
            h2_ack = 2'b00; h_ack = 2'b00; h_regwe = 1'b0;
        end else begin
            h2_ack = h_ack; h_ack = cur_ack; h_regwe = regwe;
        end
        h_req = req_v;
        h_rst = rst;
    end

    initial begin
        addr_v[0] = '0; addr_v[1] = '0;
        data_v[0] = '0; data_v[1] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        mode = 1; lowcfg = 0;
        do_write(0, 8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);

        pulse_rst();
        fork
            do_write(0, 8'hA0, 8'h01, 1'b0);
            do_write(1, 8'hB0, 8'h02, 1'b0);
        join

        lowcfg = 5;
        do_write(1, 8'h55, 8'h66, 1'b0);
        lowcfg = TO;
        do_write(0, 8'h77, 8'h88, 1'b0);
        lowcfg = 0;
        do_write(1, 8'h99, 8'hAA, 1'b0);

        lowcfg = 255;
        fork
            do_write(1, 8'hC3, 8'h3C, 1'b0);
            begin
                wait_we();
                pulse_rst();
                lowcfg = 0;
            end
        join

        for (int i = 0; i < 4; i++) begin
            do_write(0, 8'(8'h20 + i), 8'(8'hE0 - i), 1'(i % 2));
        end
        fork
            do_write(0, 8'h31, 8'h13, 1'b1);
            do_write(1, 8'h42, 8'h24, 1'b1);
        join

        mode = 0;
        fork
            rand_req(0, 30);
            rand_req(1, 30);
        join
        repeat (10) @(posedge clk);
        chk("q0_empty", 32'(q0.size()), 32'(0));
        chk("q1_empty", 32'(q1.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
